// File: rtl/seq_adder.sv
// -----------------------------------------------------------------------------
// seq_adder
//
// Multi-cycle adder/subtractor. It processes CHUNK bits per clock, from the
// least significant chunk upward, and carries between chunks in a register.
// One operation takes L = WIDTH/CHUNK clocks in RUN, then a single DONE cycle.
// The sum, cout and ovf outputs update only when the operation completes.
// Between completions they hold their last value, so partial sums never show.
//
// Parameters
//   WIDTH  operand/result width in bits; must be an integer multiple of CHUNK
//   CHUNK  bits added per clock (CHUNK == WIDTH gives a single RUN cycle)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request an operation; accepted only while busy is low
//   sub    0 = a + b, 1 = a - b (sampled with the operands on acceptance)
//   a, b   operands (sampled only on the accepting edge)
//   busy   high while the operation is running
//   done   one-cycle completion pulse
//   sum    result, modulo 2^WIDTH
//   cout   carry out of the MSB (for subtract: 1 = no borrow)
//   ovf    two's-complement signed overflow
// -----------------------------------------------------------------------------
module seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int L     = WIDTH / CHUNK;
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // b already inverted for subtract
  logic [WIDTH-1:0] acc_q;    // partial sum, kept internal until completion
  logic [CNT_W-1:0] k_q;      // index of the chunk being processed
  logic             carry_q;

  logic             accept;
  int               base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_next;

  // A new request is taken in IDLE or DONE; in DONE this lets start run
  // operations back to back with only the single done cycle in between.
  assign accept = start && (state_q != S_RUN);

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    base      = int'(k_q) * CHUNK;
    a_chunk   = a_q[base +: CHUNK];
    b_chunk   = b_q[base +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    acc_next  = acc_q;
    acc_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    // Overflow: the two operands going into the MSB have the same sign, but
    // the result sign differs from it.
    ovf_next  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                (acc_next[WIDTH-1] != a_q[WIDTH-1]);
  end

  // NOTE: the operand and partial-sum registers are reset as well. Nothing
  // reads them before an accept overwrites them, but resetting them keeps
  // X values out of simulation at negligible cost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // values from before the edge and the order of statements here does
      // not matter.
      case (state_q)
        S_RUN: begin
          acc_q   <= acc_next;
          carry_q <= chunk_sum[CHUNK];
          k_q     <= k_q + CNT_W'(1);
          if (k_q == LAST) begin
            sum     <= acc_next;
            cout    <= chunk_sum[CHUNK];
            ovf     <= ovf_next;
            state_q <= S_DONE;
          end
        end
        default: begin  // S_IDLE, S_DONE (and the unused encoding)
          if (accept) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            acc_q   <= '0;
            k_q     <= '0;
            carry_q <= sub;  // +1 completes the two's complement of b
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_adder
//
// Drives two seq_adder instances with the same stimulus: WIDTH=32 with
// CHUNK=8 (L=4), and WIDTH=32 with CHUNK=32 (L=1). A stimulus thread
// decides from the timing rules which edges accept a request. For each
// accepted request it pushes the arithmetic result into a per-instance
// queue. A monitor per instance pops the queue on every done pulse. On
// every other cycle the monitor checks that the registered outputs still
// hold the last result.
// -----------------------------------------------------------------------------
module tb_seq_adder;

  localparam int L0 = 4;
  localparam int L1 = 1;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;

  logic        busy0, done0, cout0, ovf0;
  logic [31:0] sum0;
  logic        busy1, done1, cout1, ovf1;
  logic [31:0] sum1;

  int   n_total = 0;
  int   n_pass  = 0;
  int   tcyc    = 0;
  int   free0   = 0;
  int   free1   = 0;
  int   run0    = 0;
  int   run1    = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t held0   = '0;
  exp_t held1   = '0;

  seq_adder #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  seq_adder #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference result computed with plain wide arithmetic.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic sb);
    exp_t        e;
    logic [32:0] r;
    r      = sb ? ({1'b0, av} - {1'b0, bv}) : ({1'b0, av} + {1'b0, bv});
    e.sum  = r[31:0];
    e.cout = sb ? (av >= bv) : r[32];
    if (sb) e.ovf = (av[31] != bv[31]) && (r[31] != av[31]);
    else    e.ovf = (av[31] == bv[31]) && (r[31] != av[31]);
    return e;
  endfunction

  // Drive one clock's worth of inputs and record which instances accept.
  task automatic step(input logic s, input logic [31:0] av,
                      input logic [31:0] bv, input logic sb);
    @(negedge clk);
    start = s; a = av; b = bv; sub = sb;
    @(posedge clk);
    tcyc++;
    if (s && rst_n) begin
      if (tcyc >= free0) begin
        q0.push_back(model(av, bv, sb));
        free0 = tcyc + L0 + 1;
      end
      if (tcyc >= free1) begin
        q1.push_back(model(av, bv, sb));
        free1 = tcyc + L1 + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      run0 = 0;
    end else begin
      if (busy0) run0++;
      if (done0) begin
        check("d0_latency", 64'(run0), 64'(L0));
        run0 = 0;
        check("d0_done_expected", 64'(q0.size() != 0), 64'(1));
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("d0_sum",  64'(sum0), 64'(e.sum));
          check("d0_cout", 64'(cout0), 64'(e.cout));
          check("d0_ovf",  64'(ovf0), 64'(e.ovf));
          held0 = e;
        end
      end else begin
        check("d0_hold", 64'({sum0, cout0, ovf0}), 64'(held0));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      run1 = 0;
    end else begin
      if (busy1) run1++;
      if (done1) begin
        check("d1_latency", 64'(run1), 64'(L1));
        run1 = 0;
        check("d1_done_expected", 64'(q1.size() != 0), 64'(1));
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("d1_sum",  64'(sum1), 64'(e.sum));
          check("d1_cout", 64'(cout1), 64'(e.cout));
          check("d1_ovf",  64'(ovf1), 64'(e.ovf));
          held1 = e;
        end
      end else begin
        check("d1_hold", 64'({sum1, cout1, ovf1}), 64'(held1));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state0", 64'({busy0, done0, sum0, cout0, ovf0}), 64'(0));
    check("reset_state1", 64'({busy1, done1, sum1, cout1, ovf1}), 64'(0));
    rst_n = 1'b1;

    // Carry out of the MSB, overflow corner cases, and subtract with borrow.
    step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0); idle(6);
    step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0); idle(6);
    step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1); idle(6);
    step(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1); idle(6);
    // The following operation: the monitors check that outputs hold until done.
    step(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0); idle(6);

    // A start at edge N+2 is ignored by the L=4 instance.
    step(1'b1, 32'hAAAA_0001, 32'h0F0F_0F0F, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0);
    idle(6);

    // start held high: back-to-back operations.
    for (int i = 0; i < 15; i++) step(1'b1, $urandom, $urandom, 1'($urandom));
    idle(6);

    // Reset during RUN at edge N+2 clears the outputs at once, without a clock.
    step(1'b1, 32'h0101_0101, 32'h0202_0202, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset0", 64'({busy0, done0, sum0, cout0, ovf0}), 64'(0));
    check("async_reset1", 64'({busy1, done1, sum1, cout1, ovf1}), 64'(0));
    q0.delete(); q1.delete();
    held0 = '0; held1 = '0;
    free0 = 0;  free1 = 0;
    // A start asserted while in reset is ignored.
    step(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0);
    #1;
    check("start_in_reset", 64'({busy0, busy1}), 64'(0));
    rst_n = 1'b1;
    step(1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0);
    idle(6);

    // Randomized traffic with boundary operands mixed in.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom));
    idle(8);

    check("q0_drained", 64'(q0.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
